// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU share scheduler.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] MODE_RAW = 2'b00;
  localparam logic [1:0] MODE_MIN = 2'b01;
  localparam logic [1:0] MODE_MAX = 2'b10;

  // {S2,S1,S0,Ci} for set-less-than; ALU Co=1 means B<A
  localparam logic [3:0] SLT_SEL = 4'b1001;

  // MIN and MAX are the two compound modes; 2'b11 falls back to raw
  function automatic logic is_cmp_mode(input logic [1:0] mode);
    return (mode == MODE_MIN) || (mode == MODE_MAX);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the port that did not win last time has priority.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant,
  output logic grant_id
);

  // grant whichever port is valid; on a tie, favour the one not served last
  always_comb begin
    grant    = valid0 | valid1;
    grant_id = (valid0 && valid1) ? ~last_grant : valid1;
  end

endmodule

// File: rtl/alu_share_scheduler.sv
// Shares one external 32-bit ALU between two requesters and sequences MIN/MAX.
//
// state | meaning
// IDLE  | waiting for a command; granted port sees ready this cycle
// EXEC  | latched command driven onto the ALU for exactly one cycle
// RESP  | registered result offered until resp_valid && resp_ready
module alu_share_scheduler
  import alu_sched_pkg::*;
#(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] SLT_SEL = alu_sched_pkg::SLT_SEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic [1:0]       req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  input  logic [1:0]       req1_mode,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_f,
  output logic             resp_co,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_s0,
  output logic             alu_s1,
  output logic             alu_s2,
  output logic             alu_ci,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_co
);

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             grant;
  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [3:0]       cmd_op;
  logic [1:0]       cmd_mode;
  logic             cmd_id;
  logic [3:0]       exec_sel;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign accept   = (state == IDLE) && grant;
  assign exec_sel = is_cmp_mode(cmd_mode) ? SLT_SEL : cmd_op;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state, request/response handshakes and ALU drive (zero outside EXEC)
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp_valid = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_s2     = 1'b0;
    alu_s1     = 1'b0;
    alu_s0     = 1'b0;
    alu_ci     = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        alu_a     = cmd_a;
        alu_b     = cmd_b;
        alu_s2    = exec_sel[3];
        alu_s1    = exec_sel[2];
        alu_s0    = exec_sel[1];
        alu_ci    = exec_sel[0];
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // latch the granted command and remember who won for the next tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      cmd_a      <= '0;
      cmd_b      <= '0;
      cmd_op     <= '0;
      cmd_mode   <= '0;
      cmd_id     <= 1'b0;
    end else if (accept) begin
      last_grant <= grant_id;
      cmd_id     <= grant_id;
      cmd_a      <= grant_id ? req1_a    : req0_a;
      cmd_b      <= grant_id ? req1_b    : req0_b;
      cmd_op     <= grant_id ? req1_op   : req0_op;
      cmd_mode   <= grant_id ? req1_mode : req0_mode;
    end
  end

  // capture the ALU result at the end of EXEC; MIN/MAX pick an operand from Co
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_f  <= '0;
      resp_co <= 1'b0;
      resp_id <= 1'b0;
    end else if (state == EXEC) begin
      resp_co <= alu_co;
      resp_id <= cmd_id;
      case (cmd_mode)
        MODE_MIN: resp_f <= alu_co ? cmd_b : cmd_a;
        MODE_MAX: resp_f <= alu_co ? cmd_a : cmd_b;
        default:  resp_f <= alu_f;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_scheduler.sv
// Self-checking bench for alu_share_scheduler with a behavioural ALU attached.
module tb_alu_share_scheduler;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_op, req1_op;
  logic [1:0]   req0_mode, req1_mode;
  logic         resp_valid, resp_ready, resp_id, resp_co;
  logic [W-1:0] resp_f;
  logic [W-1:0] alu_a, alu_b, alu_f;
  logic         alu_s0, alu_s1, alu_s2, alu_ci, alu_co;
  logic [W:0]   alu_out;

  int   total = 0;
  int   bad   = 0;
  logic model_last;

  always #5 clk = ~clk;

  alu_share_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_mode(req1_mode),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_f(resp_f), .resp_co(resp_co),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_s2(alu_s2),
    .alu_ci(alu_ci), .alu_f(alu_f), .alu_co(alu_co)
  );

  // behavioural 32-bit ALU: returns {co, f}; select code 100x is unsigned SLT
  function automatic logic [W:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] sel);
    logic [W:0] ci_ext;
    logic       lt;
    ci_ext = {{W{1'b0}}, sel[0]};
    lt     = (b < a);
    case (sel[3:1])
      3'b000:  return {1'b0, a} + {1'b0, b} + ci_ext;
      3'b001:  return {1'b0, a} + {1'b0, ~b} + ci_ext;
      3'b010:  return {1'b0, a & b};
      3'b011:  return {1'b0, a | b};
      3'b100:  return {lt, {(W-1){1'b0}}, lt};
      3'b101:  return {1'b0, a ^ b};
      3'b110:  return {1'b0, a};
      default: return {1'b0, b};
    endcase
  endfunction

  always_comb alu_out = alu_model(alu_a, alu_b, {alu_s2, alu_s1, alu_s0, alu_ci});
  assign alu_f  = alu_out[W-1:0];
  assign alu_co = alu_out[W];

  // expected response for a command: {co, f}
  function automatic logic [W:0] expect_resp(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] op, input logic [1:0] mode);
    if (mode == 2'b01) return {(b < a), ((b < a) ? b : a)};
    if (mode == 2'b10) return {(b < a), ((b < a) ? a : b)};
    return alu_model(a, b, op);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one command on a port and collect what the DUT reports; checks are done by callers
  task automatic single_txn(input logic port, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [3:0] op, input logic [1:0] mode,
                            output logic acc, output int lat, output logic [W-1:0] f,
                            output logic co, output logic id, output logic [3:0] sel_x,
                            output logic [W-1:0] xa, output logic [W-1:0] xb);
    if (port) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; req1_mode = mode;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; req0_mode = mode;
    end
    @(negedge clk);
    acc = port ? req1_ready : req0_ready;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    sel_x = {alu_s2, alu_s1, alu_s0, alu_ci};
    xa    = alu_a;
    xb    = alu_b;
    lat   = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    f  = resp_f;
    co = resp_co;
    id = resp_id;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0; req0_mode = '0;
    req1_a = '0; req1_b = '0; req1_op = '0; req1_mode = '0;
    tick(); tick();
    rst = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
    total++; if (resp_f !== '0) begin bad++; $display("FAIL reset_f: got %h want 0", resp_f); end
    total++; if (resp_co !== 1'b0) begin bad++; $display("FAIL reset_co: got %b want 0", resp_co); end
    total++; if (resp_id !== 1'b0) begin bad++; $display("FAIL reset_id: got %b want 0", resp_id); end
    total++;
    if ({alu_a, alu_b, alu_s2, alu_s1, alu_s0, alu_ci} !== '0) begin
      bad++; $display("FAIL reset_alu: got a=%h b=%h sel=%b want all 0", alu_a, alu_b,
                      {alu_s2, alu_s1, alu_s0, alu_ci});
    end
    total++; if ({req1_ready, req0_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready}); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total++; if ({req1_ready, req0_ready} !== 2'b01) begin bad++; $display("FAIL reset_first_grant: got %b want 01", {req1_ready, req0_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_raw_port0();
    logic acc, co, id; int lat; logic [W-1:0] f, xa, xb; logic [3:0] sx; logic [W:0] e;
    resp_ready = 1'b1;
    e = alu_model(32'h41010101, 32'h21616161, 4'b1001);
    single_txn(1'b0, 32'h41010101, 32'h21616161, 4'b1001, 2'b00, acc, lat, f, co, id, sx, xa, xb);
    model_last = 1'b0;
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL raw_accept: got %b want 1", acc); end
    total++; if (lat != 2) begin bad++; $display("FAIL raw_latency: got %0d want 2", lat); end
    total++; if (id !== 1'b0) begin bad++; $display("FAIL raw_id: got %b want 0", id); end
    total++; if (co !== 1'b1) begin bad++; $display("FAIL raw_co: got %b want 1", co); end
    total++; if (f !== e[W-1:0]) begin bad++; $display("FAIL raw_f: got %h want %h", f, e[W-1:0]); end
  endtask

  task automatic test_minmax_port1();
    logic acc, co, id; int lat; logic [W-1:0] f, xa, xb; logic [3:0] sx;
    resp_ready = 1'b1;
    single_txn(1'b1, 32'h41010101, 32'h21616161, 4'b0000, 2'b10, acc, lat, f, co, id, sx, xa, xb);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL max_accept: got %b want 1", acc); end
    total++; if (f !== 32'h41010101) begin bad++; $display("FAIL max_f: got %h want 41010101", f); end
    total++; if (co !== 1'b1) begin bad++; $display("FAIL max_co: got %b want 1", co); end
    total++; if (id !== 1'b1) begin bad++; $display("FAIL max_id: got %b want 1", id); end
    single_txn(1'b1, 32'h41010101, 32'h21616161, 4'b0110, 2'b01, acc, lat, f, co, id, sx, xa, xb);
    model_last = 1'b1;
    total++; if (f !== 32'h21616161) begin bad++; $display("FAIL min_f: got %h want 21616161", f); end
    total++; if (id !== 1'b1) begin bad++; $display("FAIL min_id: got %b want 1", id); end
  endtask

  task automatic test_max_lt();
    logic acc, co, id; int lat; logic [W-1:0] f, xa, xb; logic [3:0] sx;
    resp_ready = 1'b1;
    single_txn(1'b0, 32'h25010107, 32'h61616167, 4'b0000, 2'b10, acc, lat, f, co, id, sx, xa, xb);
    model_last = 1'b0;
    total++; if (co !== 1'b0) begin bad++; $display("FAIL maxlt_co: got %b want 0", co); end
    total++; if (f !== 32'h61616167) begin bad++; $display("FAIL maxlt_f: got %h want 61616167", f); end
    total++; if (sx !== 4'b1001) begin bad++; $display("FAIL maxlt_exec_sel: got %b want 1001", sx); end
    total++;
    if (xa !== 32'h25010107 || xb !== 32'h61616167) begin
      bad++; $display("FAIL maxlt_exec_ops: got %h/%h want 25010107/61616167", xa, xb);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a0, b0, a1, b1; logic [3:0] op0, op1; logic [W:0] e;
    int n, cyc, t_prev;
    rst = 1'b1; tick(); rst = 1'b0;
    model_last = 1'b1;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    op0 = 4'($urandom); op1 = 4'($urandom);
    resp_ready = 1'b1;
    req0_a = a0; req0_b = b0; req0_op = op0; req0_mode = 2'b00;
    req1_a = a1; req1_b = b1; req1_op = op1; req1_mode = 2'b11;
    req0_valid = 1'b1; req1_valid = 1'b1;
    n = 0; cyc = 0; t_prev = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      if (resp_valid) begin
        e = (n % 2 == 0) ? alu_model(a0, b0, op0) : alu_model(a1, b1, op1);
        total++; if (resp_id !== 1'(n % 2)) begin bad++; $display("FAIL b2b_id[%0d]: got %b want %0d", n, resp_id, n % 2); end
        total++; if (resp_f !== e[W-1:0]) begin bad++; $display("FAIL b2b_f[%0d]: got %h want %h", n, resp_f, e[W-1:0]); end
        if (n > 0) begin
          total++; if (cyc - t_prev != 3) begin bad++; $display("FAIL b2b_interval[%0d]: got %0d want 3", n, cyc - t_prev); end
        end
        t_prev = cyc;
        n++;
      end
      tick();
      cyc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    model_last = 1'b1;
    total++; if (n != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", n); end
    tick();
  endtask

  task automatic test_stall();
    logic [W-1:0] a, b, f0; logic [3:0] op; logic co0, id0; logic [W:0] e; int k;
    a = $urandom; b = $urandom; op = 4'($urandom);
    e = alu_model(a, b, op);
    resp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; req1_mode = 2'b00;
    @(negedge clk);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_mode = 2'b00;
    model_last = 1'b1;
    k = 0;
    @(negedge clk);
    while (!resp_valid && k < 10) begin @(posedge clk); @(negedge clk); k++; end
    f0 = resp_f; co0 = resp_co; id0 = resp_id;
    total++; if (f0 !== e[W-1:0]) begin bad++; $display("FAIL stall_f: got %h want %h", f0, e[W-1:0]); end
    total++; if (co0 !== e[W]) begin bad++; $display("FAIL stall_co: got %b want %b", co0, e[W]); end
    total++; if (id0 !== 1'b1) begin bad++; $display("FAIL stall_id: got %b want 1", id0); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (resp_valid !== 1'b1 || resp_f !== e[W-1:0] || resp_co !== e[W] || resp_id !== 1'b1 ||
          {req1_ready, req0_ready} !== 2'b00) begin
        bad++; $display("FAIL stall_hold[%0d]: got v=%b f=%h co=%b id=%b rdy=%b want 1/%h/%b/1/00",
                        i, resp_valid, resp_f, resp_co, resp_id, {req1_ready, req0_ready}, e[W-1:0], e[W]);
      end
      tick();
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    total++; if ({req1_ready, req0_ready} !== 2'b00) begin bad++; $display("FAIL stall_handshake_ready: got %b want 00", {req1_ready, req0_ready}); end
    tick();
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL stall_done: got %b want 0", resp_valid); end
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL stall_idle_ready: got %b want 1", req0_ready); end
    req0_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_exec();
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'hdeadbeef; req0_b = 32'h12345678; req0_op = 4'b1100; req0_mode = 2'b00;
    @(negedge clk);
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rstexec_valid: got %b want 0", resp_valid); end
    total++; if (resp_f !== '0) begin bad++; $display("FAIL rstexec_f: got %h want 0", resp_f); end
    total++;
    if ({alu_a, alu_b, alu_s2, alu_s1, alu_s0, alu_ci} !== '0) begin
      bad++; $display("FAIL rstexec_alu: got a=%h b=%h want 0", alu_a, alu_b);
    end
    tick();
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rstexec_no_resp: got %b want 0", resp_valid); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total++; if ({req1_ready, req0_ready} !== 2'b01) begin bad++; $display("FAIL rstexec_grant: got %b want 01", {req1_ready, req0_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    model_last = 1'b1;
    tick();
  endtask

  // random traffic against a timeline model: accepted at t, offered from t+2, free after handshake
  task automatic test_random();
    logic busy, g, pv, exec_now; int resp_at;
    logic [W-1:0] ea, eb; logic [3:0] esel; logic [W:0] e; logic eid; logic [1:0] pr;
    busy = 1'b0; resp_at = 0; ea = '0; eb = '0; esel = '0; e = '0; eid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
      req0_a = $urandom; req0_b = ($urandom_range(0, 7) == 0) ? req0_a : $urandom;
      req1_a = $urandom; req1_b = ($urandom_range(0, 7) == 0) ? req1_a : $urandom;
      req0_op = 4'($urandom); req1_op = 4'($urandom);
      req0_mode = 2'($urandom); req1_mode = 2'($urandom);
      resp_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      g  = (req0_valid && req1_valid) ? ~model_last : req1_valid;
      pr = (!busy && (req0_valid || req1_valid)) ? (g ? 2'b10 : 2'b01) : 2'b00;
      total++; if ({req1_ready, req0_ready} !== pr) begin bad++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, {req1_ready, req0_ready}, pr); end
      pv = busy && (cyc >= resp_at);
      total++; if (resp_valid !== pv) begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, resp_valid, pv); end
      if (pv) begin
        total++;
        if (resp_f !== e[W-1:0] || resp_co !== e[W] || resp_id !== eid) begin
          bad++; $display("FAIL rnd_resp@%0d: got f=%h co=%b id=%b want f=%h co=%b id=%b",
                          cyc, resp_f, resp_co, resp_id, e[W-1:0], e[W], eid);
        end
      end
      exec_now = busy && (cyc == resp_at - 1);
      total++;
      if (exec_now ? ({alu_a, alu_b, alu_s2, alu_s1, alu_s0, alu_ci} !== {ea, eb, esel})
                   : ({alu_a, alu_b, alu_s2, alu_s1, alu_s0, alu_ci} !== '0)) begin
        bad++; $display("FAIL rnd_alu@%0d: got a=%h b=%h sel=%b exec=%b want a=%h b=%h sel=%b",
                        cyc, alu_a, alu_b, {alu_s2, alu_s1, alu_s0, alu_ci}, exec_now, ea, eb, esel);
      end
      if (!busy && (req0_valid || req1_valid)) begin
        busy = 1'b1; resp_at = cyc + 2; model_last = g; eid = g;
        ea   = g ? req1_a : req0_a;
        eb   = g ? req1_b : req0_b;
        e    = g ? expect_resp(req1_a, req1_b, req1_op, req1_mode)
                 : expect_resp(req0_a, req0_b, req0_op, req0_mode);
        if (g) esel = (req1_mode == 2'b01 || req1_mode == 2'b10) ? 4'b1001 : req1_op;
        else   esel = (req0_mode == 2'b01 || req0_mode == 2'b10) ? 4'b1001 : req0_op;
      end else if (pv && resp_ready) begin
        busy = 1'b0;
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    tick(); tick(); tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_raw_port0();
    test_minmax_port1();
    test_max_lt();
    test_back_to_back();
    test_stall();
    test_reset_exec();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_scheduler.md
Name: alu_share_scheduler

Overview:
- Shares one alu_32_bit instance between two requesters (port 0 and port 1) using round-robin arbitration.
- Each accepted command is issued to the ALU for one cycle. The block registers F/Co and returns the result on a single response channel tagged with the requester ID.
- Also sequences the compound MIN/MAX operations. These issue the SLT code, then select operand A or B from the registered Co.
- Sits between the two command sources and the ALU datapath.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- SLT_SEL, 4'b1001, {S2,S1,S0,Ci} code forced for MIN/MAX (SLT: S2=1, S1=0, S0=0, Ci=1; Co=1 means B<A).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 command valid
- req0_ready  out  1  port 0 command accepted this cycle
- req0_a, req0_b  in  WIDTH  port 0 operands
- req0_op  in  4  raw {S2,S1,S0,Ci} select
- req0_mode  in  2  00 raw, 01 MIN, 10 MAX, 11 treated as raw
- req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_mode: same as port 0, for port 1
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumer ready
- resp_id  out  1  ID of the originating requester
- resp_f  out  WIDTH  result
- resp_co  out  1  registered ALU Co
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_s0, alu_s1, alu_s2, alu_ci  out  1  ALU selects
- alu_f  in  WIDTH  ALU result
- alu_co  in  1  ALU carry/compare output

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset value: state=IDLE, last_grant=1 (so port 0 wins first), and every output register is 0.
- Reset mid-operation: a pending response is discarded and the block returns to IDLE on the next edge.
- IDLE, grant selection:
  - Only one valid: grant that port.
  - Both valid: grant !last_grant.
- IDLE, acceptance:
  - reqN_ready=1 is combinational, only for the granted port and only in IDLE.
  - reqN_ready depends on reqN_valid; requesters must not make valid depend on ready.
- On acceptance, on the edge:
  - Latch a, b, op, mode and ID.
  - Update last_grant.
  - Move to EXEC.
- EXEC (exactly one cycle):
  - alu_a/alu_b are driven from the latched operands.
  - Selects are driven from the latched op for raw mode, or from SLT_SEL for MIN/MAX.
  - At the end of EXEC, capture alu_co into resp_co and set resp_id.
  - Raw mode: resp_f=alu_f.
  - MAX: resp_f = alu_co ? A : B.
  - MIN: resp_f = alu_co ? B : A.
  - Move to RESP.
- ALU outputs in IDLE and RESP: all ALU outputs are held at 0.
- RESP:
  - resp_valid=1.
  - resp_f, resp_co and resp_id are held stable until resp_valid && resp_ready.
  - On that handshake, return to IDLE and clear resp_valid.
  - Both reqN_ready outputs are 0.
- Latency:
  - Accept edge at cycle N; resp_valid is high from cycle N+2.
  - Minimum issue interval is 3 cycles.
  - No new grant is made in the cycle of the response handshake.
- A requester whose valid drops before it is granted is simply not served; no state is retained.
- Width rule: no extension or truncation; operands pass through unchanged.

Decomposition:
- Package alu_sched_pkg holds:
  - state enum {IDLE, EXEC, RESP};
  - mode constants MODE_RAW=2'b00, MODE_MIN=2'b01, MODE_MAX=2'b10;
  - SLT_SEL.
- Sub-module rr_arb2: 2-way round-robin grant logic (inputs valid0/valid1/last_grant, outputs grant/grant_id).
- The ALU stays external. The bench connects alu_32_bit to the alu_* ports.

Test Plan:
- Port 0 only, raw op 4'b1001, a=0x41010101, b=0x21616161:
  - Accepted the same cycle.
  - resp_valid 2 cycles later, with resp_id=0, resp_co=1, resp_f = ALU F.
- Port 1, MAX, same operands -> resp_f=0x41010101, resp_co=1, resp_id=1. Repeat with MIN -> resp_f=0x21616161.
- Port 0, MAX, a=0x25010107, b=0x61616167 -> resp_co=0, resp_f=0x61616167. During EXEC, alu_s2..ci = 1,0,0,1.
- Both ports valid continuously, resp_ready=1, 4 transactions -> resp_id sequence 0,1,0,1, one response every 3 cycles.
- resp_ready held 0 for 5 cycles in RESP:
  - resp_f/co/id stable and both ready outputs 0 throughout.
  - Completes on the first cycle ready=1.
- rst pulsed during EXEC -> next cycle: state IDLE, resp_valid=0, ALU outputs 0. A subsequent simultaneous request grants port 0.
